// File: rtl/encoder_4to2_stream.sv
// Streams the binary index of every set bit of an accepted request vector, one per beat.
// Define ENCODER_MSB_FIRST_EN to emit the highest set bit first (descending order).
module encoder_4to2_stream #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] pend_reg;
  logic             zero_err_reg;
  logic [WIDTH-1:0] sel_mask;
  logic [IDX_W-1:0] sel_idx;

  // Index of the bit to emit next, decoded only from the pending register.
  always_comb begin
    sel_idx = '0;
`ifdef ENCODER_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_reg[i]) sel_idx = IDX_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_reg[i]) sel_idx = IDX_W'(i);
    end
`endif
  end

  assign sel_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << sel_idx;
  assign out_idx   = sel_idx;
  assign out_last  = (pend_reg != '0) && ((pend_reg & (pend_reg - WIDTH'(1))) == '0);
  assign out_valid = (state_reg == EMIT);
  // Gated by rst_n so the upstream never sees a handshake while reset is held.
  assign in_ready  = rst_n && (state_reg == IDLE);
  assign zero_err  = zero_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pend_reg     <= '0;
      zero_err_reg <= 1'b0;
    end else begin
      zero_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (in_vec == '0) begin
              zero_err_reg <= 1'b1;
            end else begin
              pend_reg  <= in_vec;
              state_reg <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            pend_reg <= pend_reg & ~sel_mask;
            if (out_last) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_4to2_stream.sv
// Directed bench for encoder_4to2_stream: handshake, ordering, backpressure, zero vector, reset.
module tb_encoder_4to2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_idx;
  logic       out_last;
  logic       zero_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  encoder_4to2_stream #(.WIDTH(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_err  (zero_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Present a vector for one edge; returns at the negedge after acceptance.
  task automatic send(input logic [3:0] vec);
    chk("send_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_vec   = vec;
    @(negedge clk);
    in_valid = 1'b0;
    $display("sent vec=%b", vec);
  endtask

  // Check the current beat, then let one edge consume it.
  task automatic beat(input string tag, input int idx, input logic last);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_idx"}, out_idx, idx);
    chk({tag, "_last"}, out_last, last);
    chk({tag, "_in_ready"}, in_ready, 0);
    $display("beat %s idx=%0d last=%0b", tag, out_idx, out_last);
    @(negedge clk);
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_valid0"}, out_valid, 0);
    chk({tag, "_ready1"}, in_ready, 1);
  endtask

  initial begin
    logic [1:0] ab;
    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_zero_err", zero_err, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    @(negedge clk);

    // 1010 at full rate
    send(4'b1010);
`ifdef ENCODER_MSB_FIRST_EN
    beat("v1010_b0", 3, 0);
    beat("v1010_b1", 1, 1);
`else
    beat("v1010_b0", 1, 0);
    beat("v1010_b1", 3, 1);
`endif
    idle_check("v1010_after");
    @(negedge clk);

    // Decoder round trip: one beat per one-hot vector
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      send(4'b0001 << ab);
      beat($sformatf("rt%0d", i), i, 1);
      idle_check($sformatf("rt%0d_after", i));
    end

    // All-zero vector
    send(4'b0000);
    chk("zero_err_pulse", zero_err, 1);
    idle_check("zero_a");
    @(negedge clk);
    chk("zero_err_clear", zero_err, 0);
    idle_check("zero_b");

    // 1111 with two stall cycles on the second beat
    send(4'b1111);
`ifdef ENCODER_MSB_FIRST_EN
    beat("f_b0", 3, 0);
    out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("f_stall%0d_valid", s), out_valid, 1);
      chk($sformatf("f_stall%0d_idx", s), out_idx, 2);
      chk($sformatf("f_stall%0d_last", s), out_last, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    beat("f_b1", 2, 0);
    beat("f_b2", 1, 0);
    beat("f_b3", 0, 1);
`else
    beat("f_b0", 0, 0);
    out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("f_stall%0d_valid", s), out_valid, 1);
      chk($sformatf("f_stall%0d_idx", s), out_idx, 1);
      chk($sformatf("f_stall%0d_last", s), out_last, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    beat("f_b1", 1, 0);
    beat("f_b2", 2, 0);
    beat("f_b3", 3, 1);
`endif
    idle_check("f_after");

    // Reset in the middle of 1011
    send(4'b1011);
`ifdef ENCODER_MSB_FIRST_EN
    beat("r_b0", 3, 0);
`else
    beat("r_b0", 0, 0);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_valid_in_rst", out_valid, 0);
    chk("r_ready_in_rst", in_ready, 0);
    rst_n = 1'b1;
    #1;
    idle_check("r_release");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_check($sformatf("r_quiet%0d", k));
      chk($sformatf("r_quiet%0d_zerr", k), zero_err, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/encoder_4to2_stream.md
Name: encoder_4to2_stream

Overview:
- Sequential counterpart of the team's 2-to-4 decoders: takes a WIDTH-bit request/one-hot vector and emits the binary index of every set bit, one per beat, over a valid/ready stream.
- For a one-hot input (e.g. a decoder output), it returns exactly one index, which closes the decode/encode round trip.
- Sits between a decoded request bus and any consumer that needs encoded indices, e.g. an arbiter grant log or an interrupt source serializer.

Parameters:
- WIDTH, 4, number of input request bits.
- IDX_W, 2, index width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  WIDTH  request vector.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts the current index.
- out_idx  output  IDX_W  encoded index of the current set bit.
- out_last  output  1  current index is the final one from this vector.
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state updates on the rising clk edge.
- Reset (rst_n low at an edge):
  - State goes to IDLE and the pending register is cleared to 0.
  - Outputs: out_valid=0, out_idx=0, out_last=0, zero_err=0.
  - in_ready=0 while rst_n is low; in_ready=1 in the first cycle after release.
- States: IDLE and EMIT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready with in_vec!=0: pend<=in_vec and go to EMIT.
  - On in_valid&&in_ready with in_vec==0: zero_err=1 for exactly the next cycle; stay in IDLE; no output beat.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_idx = index of the lowest set bit of pend.
  - out_last=1 iff pend has exactly one bit set.
  - On out_valid&&out_ready: clear that bit in pend. If out_last=1, go to IDLE; otherwise stay in EMIT.
- Output timing:
  - out_idx and out_last are decoded only from the pend register; there is no combinational path from in_* to out_*.
  - out_ready does not affect in_ready in the same cycle.
- Latency:
  - Vector accepted at edge N gives its first out_valid in cycle N+1.
  - Each set bit takes one beat at full out_ready.
  - Each vector costs popcount(in_vec) cycles plus 1 IDLE cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_idx, out_last and pend hold stable.
- in_valid during EMIT is ignored (in_ready=0). Upstream must hold in_vec until it is accepted.
- Reset mid-EMIT: pending bits are discarded. No out_valid in the cycle after reset, and no residual beats after release.
- Widths: out_idx is zero-extended index arithmetic in IDX_W bits. WIDTH must be a power of two ≥2.

Optional Feature:
- Macro: ENCODER_MSB_FIRST_EN.
- Defined: EMIT selects the highest set bit of pend, so indices come out in descending order. out_last has the same meaning (single remaining bit).
- Undefined (default): lowest set bit first, ascending order.
- Handshake, latency and zero_err behaviour are identical in both builds.

Test Plan:
- Reset then in_vec=4'b1010, out_ready=1 → beat idx=1 last=0, then idx=3 last=1; in_ready=1 in the following cycle.
- Round trip: drive the 2-to-4 decoder with {a,b}=00,01,10,11 into in_vec → exactly one beat each, out_idx=0,1,2,3, last=1.
- in_vec=4'b0000 accepted → zero_err=1 for one cycle; out_valid stays 0; in_ready stays 1.
- in_vec=4'b1111 with out_ready low for 2 cycles on the second beat → idx=1 held stable; sequence 0,1,2,3 with last only on 3.
- in_vec=4'b1011, rst_n low for one edge after the first beat (idx=0) → next cycle out_valid=0; after release in_ready=1 and no beats for 1 or 3.
- With ENCODER_MSB_FIRST_EN: in_vec=4'b1010 → idx=3 last=0, then idx=1 last=1.
